// File: rtl/complete_stage_if.sv
// Dispatch, FU-result, forward, retire and end-of-program signals of the complete/retire stage.
// The producer side (dispatch + FUs) uses master; the ROB back end uses slave.
interface complete_stage_if #(
    parameter int DATA_W = 32,
    parameter int PREG_W = 6,
    parameter int PC_W   = 7,
    parameter int IDX_W  = 4
);
    logic              update_rob;
    logic [6:0]        rob_opcode_1,   rob_opcode_2;
    logic [PREG_W-1:0] rob_p_reg_1,    rob_p_reg_2;
    logic [PREG_W-1:0] o_rob_p_reg_1,  o_rob_p_reg_2;
    logic [4:0]        rob_rd_1,       rob_rd_2;
    logic [PC_W-1:0]   rob_pc_1,       rob_pc_2;
    logic [IDX_W-1:0]  rob_idx_1,      rob_idx_2;
    logic              rob_ready;

    logic [DATA_W-1:0] result_c1,       result_c2,       result_c3;
    logic [PREG_W-1:0] result_dest_c1,  result_dest_c2,  result_dest_c3;
    logic              result_valid_c1, result_valid_c2, result_valid_c3;
    logic [IDX_W-1:0]  result_ROB_c1,   result_ROB_c2,   result_ROB_c3;
    logic [1:0]        result_FU_c1,    result_FU_c2,    result_FU_c3;
    logic [PC_W-1:0]   result_pc_c1,    result_pc_c2,    result_pc_c3;

    logic              forward_flag_1,   forward_flag_2,   forward_flag_3;
    logic [PREG_W-1:0] dest_R_1,         dest_R_2,         dest_R_3;
    logic [DATA_W-1:0] forwarded_data_1, forwarded_data_2, forwarded_data_3;

    logic              retire_flag_1,   retire_flag_2;
    logic [4:0]        retire_index_1,  retire_index_2;
    logic [DATA_W-1:0] retire_result_1, retire_result_2;
    logic [PREG_W-1:0] fp_ind_1,        fp_ind_2;

    logic [31:0]       total_instr_count;
    logic              pr_flag;

    modport master (
        output update_rob, rob_opcode_1, rob_opcode_2, rob_p_reg_1, rob_p_reg_2,
               o_rob_p_reg_1, o_rob_p_reg_2, rob_rd_1, rob_rd_2, rob_pc_1, rob_pc_2,
               result_c1, result_c2, result_c3, result_dest_c1, result_dest_c2, result_dest_c3,
               result_valid_c1, result_valid_c2, result_valid_c3,
               result_ROB_c1, result_ROB_c2, result_ROB_c3,
               result_FU_c1, result_FU_c2, result_FU_c3,
               result_pc_c1, result_pc_c2, result_pc_c3, total_instr_count,
        input  rob_idx_1, rob_idx_2, rob_ready,
               forward_flag_1, forward_flag_2, forward_flag_3,
               dest_R_1, dest_R_2, dest_R_3,
               forwarded_data_1, forwarded_data_2, forwarded_data_3,
               retire_flag_1, retire_flag_2, retire_index_1, retire_index_2,
               retire_result_1, retire_result_2, fp_ind_1, fp_ind_2, pr_flag
    );

    modport slave (
        input  update_rob, rob_opcode_1, rob_opcode_2, rob_p_reg_1, rob_p_reg_2,
               o_rob_p_reg_1, o_rob_p_reg_2, rob_rd_1, rob_rd_2, rob_pc_1, rob_pc_2,
               result_c1, result_c2, result_c3, result_dest_c1, result_dest_c2, result_dest_c3,
               result_valid_c1, result_valid_c2, result_valid_c3,
               result_ROB_c1, result_ROB_c2, result_ROB_c3,
               result_FU_c1, result_FU_c2, result_FU_c3,
               result_pc_c1, result_pc_c2, result_pc_c3, total_instr_count,
        output rob_idx_1, rob_idx_2, rob_ready,
               forward_flag_1, forward_flag_2, forward_flag_3,
               dest_R_1, dest_R_2, dest_R_3,
               forwarded_data_1, forwarded_data_2, forwarded_data_3,
               retire_flag_1, retire_flag_2, retire_index_1, retire_index_2,
               retire_result_1, retire_result_2, fp_ind_1, fp_ind_2, pr_flag
    );
endinterface

// File: rtl/complete_stage.sv
// 16-entry ROB: 2 allocs, 3 completions, 2 in-order retires per cycle; forward and retire outputs 1 cycle late.
// Backpressure: rob_ready drops below 2 free entries and a pair offered while it is low is dropped whole.
module complete_stage #(
    parameter int ROB_DEPTH = 16,
    parameter int DATA_W    = 32,
    parameter int PREG_W    = 6,
    parameter int PC_W      = 7
) (
    input logic             clk,
    input logic             rst_n,
    complete_stage_if.slave bus
);
    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        TYPE_REG   = 2'd0,
        TYPE_STORE = 2'd1,
        TYPE_LOAD  = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic              v;
        logic              comp;
        rob_type_e         typ;
        logic [4:0]        rd;
        logic [PREG_W-1:0] old_preg;
        logic [DATA_W-1:0] result;
    } rob_entry_t;

    function automatic rob_type_e decode_type(input logic [6:0] op);
        if (op == 7'b0100011)      return TYPE_STORE;
        else if (op == 7'b0000011) return TYPE_LOAD;
        else                       return TYPE_REG;
    endfunction

    rob_entry_t        rob [ROB_DEPTH];
    logic [IDX_W-1:0]  head, tail, head_p1, slot2_idx;
    logic [CNT_W-1:0]  count, n_alloc, n_ret;
    logic [31:0]       ret_cnt;
    logic              rob_ready, alloc_ok, slot1_vld, slot2_vld, ret1, ret2;

    logic              lane_vld  [3];
    logic [IDX_W-1:0]  lane_rob  [3];
    logic [DATA_W-1:0] lane_dat  [3];
    logic [PREG_W-1:0] lane_dest [3];

    logic              fwd_vld [3];
    logic [PREG_W-1:0] fwd_dest [3];
    logic [DATA_W-1:0] fwd_dat [3];

    logic [PC_W-1:0]   unused_pc;
    logic [1:0]        unused_fu;
    logic [PREG_W-1:0] unused_preg;

    // PCs, FU ids and new pregs are informational only at this stage.
    assign unused_pc   = bus.rob_pc_1 ^ bus.rob_pc_2 ^ bus.result_pc_c1 ^ bus.result_pc_c2 ^ bus.result_pc_c3;
    assign unused_fu   = bus.result_FU_c1 ^ bus.result_FU_c2 ^ bus.result_FU_c3;
    assign unused_preg = bus.rob_p_reg_1 ^ bus.rob_p_reg_2;

    assign lane_vld[0]  = bus.result_valid_c1;
    assign lane_vld[1]  = bus.result_valid_c2;
    assign lane_vld[2]  = bus.result_valid_c3;
    assign lane_rob[0]  = bus.result_ROB_c1;
    assign lane_rob[1]  = bus.result_ROB_c2;
    assign lane_rob[2]  = bus.result_ROB_c3;
    assign lane_dat[0]  = bus.result_c1;
    assign lane_dat[1]  = bus.result_c2;
    assign lane_dat[2]  = bus.result_c3;
    assign lane_dest[0] = bus.result_dest_c1;
    assign lane_dest[1] = bus.result_dest_c2;
    assign lane_dest[2] = bus.result_dest_c3;

    assign rob_ready = (count <= CNT_W'(ROB_DEPTH - 2));
    assign alloc_ok  = bus.update_rob & rob_ready;
    assign slot1_vld = alloc_ok & (|bus.rob_opcode_1);
    assign slot2_vld = alloc_ok & (|bus.rob_opcode_2);
    // A bubble in slot 1 lets slot 2 take the tail so entries stay contiguous.
    assign slot2_idx = slot1_vld ? tail + 1'b1 : tail;
    assign n_alloc   = CNT_W'(slot1_vld) + CNT_W'(slot2_vld);

    assign head_p1 = head + 1'b1;
    assign ret1    = rob[head].v & rob[head].comp;
    assign ret2    = ret1 & rob[head_p1].v & rob[head_p1].comp;
    assign n_ret   = CNT_W'(ret1) + CNT_W'(ret2);

    assign bus.rob_ready = rob_ready;
    assign bus.rob_idx_1 = tail;
    assign bus.rob_idx_2 = tail + 1'b1;

    assign bus.forward_flag_1   = fwd_vld[0];
    assign bus.forward_flag_2   = fwd_vld[1];
    assign bus.forward_flag_3   = fwd_vld[2];
    assign bus.dest_R_1         = fwd_dest[0];
    assign bus.dest_R_2         = fwd_dest[1];
    assign bus.dest_R_3         = fwd_dest[2];
    assign bus.forwarded_data_1 = fwd_dat[0];
    assign bus.forwarded_data_2 = fwd_dat[1];
    assign bus.forwarded_data_3 = fwd_dat[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
            for (int k = 0; k < 3; k++) begin
                fwd_vld[k]  <= 1'b0;
                fwd_dest[k] <= '0;
                fwd_dat[k]  <= '0;
            end
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            ret_cnt             <= '0;
            bus.retire_flag_1   <= 1'b0;
            bus.retire_flag_2   <= 1'b0;
            bus.retire_index_1  <= '0;
            bus.retire_index_2  <= '0;
            bus.retire_result_1 <= '0;
            bus.retire_result_2 <= '0;
            bus.fp_ind_1        <= '0;
            bus.fp_ind_2        <= '0;
            bus.pr_flag         <= 1'b0;
        end else begin
            // Ascending lane order: the highest lane wins when two target one entry.
            for (int k = 0; k < 3; k++) begin
                if (lane_vld[k] && rob[lane_rob[k]].v) begin
                    rob[lane_rob[k]].result <= lane_dat[k];
                    rob[lane_rob[k]].comp   <= 1'b1;
                end
                fwd_vld[k] <= lane_vld[k];
                if (lane_vld[k]) begin
                    fwd_dest[k] <= lane_dest[k];
                    fwd_dat[k]  <= lane_dat[k];
                end
            end

            if (ret1) rob[head]    <= '0;
            if (ret2) rob[head_p1] <= '0;

            if (slot1_vld)
                rob[tail] <= '{v: 1'b1, comp: 1'b0, typ: decode_type(bus.rob_opcode_1),
                               rd: bus.rob_rd_1, old_preg: bus.o_rob_p_reg_1, result: '0};
            if (slot2_vld)
                rob[slot2_idx] <= '{v: 1'b1, comp: 1'b0, typ: decode_type(bus.rob_opcode_2),
                                    rd: bus.rob_rd_2, old_preg: bus.o_rob_p_reg_2, result: '0};

            head    <= head + n_ret[IDX_W-1:0];
            tail    <= tail + n_alloc[IDX_W-1:0];
            count   <= count + n_alloc - n_ret;
            ret_cnt <= ret_cnt + 32'(n_ret);

            bus.retire_flag_1   <= ret1;
            bus.retire_index_1  <= (ret1 && rob[head].typ != TYPE_STORE) ? rob[head].rd : 5'd0;
            bus.retire_result_1 <= ret1 ? rob[head].result : '0;
            bus.fp_ind_1        <= ret1 ? rob[head].old_preg : '0;
            bus.retire_flag_2   <= ret2;
            bus.retire_index_2  <= (ret2 && rob[head_p1].typ != TYPE_STORE) ? rob[head_p1].rd : 5'd0;
            bus.retire_result_2 <= ret2 ? rob[head_p1].result : '0;
            bus.fp_ind_2        <= ret2 ? rob[head_p1].old_preg : '0;

            if (count == '0 && ret_cnt != 32'd0 && ret_cnt == bus.total_instr_count)
                bus.pr_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_complete_stage.sv
// Directed bench for complete_stage: expected forwards/retires are queued at stimulus time
// and popped by a negedge monitor whenever the DUT raises a forward or retire flag.
module tb_complete_stage;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [37:0] fq [3][$];
    logic [42:0] rq [$];

    complete_stage_if #(.DATA_W(32), .PREG_W(6), .PC_W(7), .IDX_W(4)) bus ();

    complete_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic compare(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pop_fwd(input int k, input logic [5:0] dest, input logic [31:0] dat);
        logic [37:0] e;
        if (fq[k].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fwd%0d: unexpected forward dest %0d data %0h", k + 1, dest, dat);
        end else begin
            e = fq[k].pop_front();
            compare($sformatf("fwd%0d", k + 1), {26'd0, dest, dat}, {26'd0, e});
        end
    endtask

    task automatic pop_ret(input int s, input logic [4:0] idx, input logic [31:0] res, input logic [5:0] fp);
        logic [42:0] e;
        if (rq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL retire%0d: unexpected retire idx %0d result %0h fp %0d", s, idx, res, fp);
        end else begin
            e = rq.pop_front();
            compare($sformatf("retire%0d", s), {21'd0, idx, res, fp}, {21'd0, e});
        end
    endtask

    always @(negedge clk) begin
        if (bus.forward_flag_1) pop_fwd(0, bus.dest_R_1, bus.forwarded_data_1);
        if (bus.forward_flag_2) pop_fwd(1, bus.dest_R_2, bus.forwarded_data_2);
        if (bus.forward_flag_3) pop_fwd(2, bus.dest_R_3, bus.forwarded_data_3);
        if (bus.retire_flag_1) pop_ret(1, bus.retire_index_1, bus.retire_result_1, bus.fp_ind_1);
        if (bus.retire_flag_2) pop_ret(2, bus.retire_index_2, bus.retire_result_2, bus.fp_ind_2);
    end

    task automatic clear_inputs();
        bus.update_rob      = 1'b0;
        bus.result_valid_c1 = 1'b0;
        bus.result_valid_c2 = 1'b0;
        bus.result_valid_c3 = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic alloc(input logic [6:0] op1, input logic [5:0] p1, input logic [5:0] o1, input logic [4:0] rd1,
                         input logic [6:0] op2, input logic [5:0] p2, input logic [5:0] o2, input logic [4:0] rd2);
        bus.update_rob    = 1'b1;
        bus.rob_opcode_1  = op1;
        bus.rob_p_reg_1   = p1;
        bus.o_rob_p_reg_1 = o1;
        bus.rob_rd_1      = rd1;
        bus.rob_pc_1      = bus.rob_pc_1 + 7'd2;
        bus.rob_opcode_2  = op2;
        bus.rob_p_reg_2   = p2;
        bus.o_rob_p_reg_2 = o2;
        bus.rob_rd_2      = rd2;
        bus.rob_pc_2      = bus.rob_pc_1 + 7'd1;
    endtask

    task automatic lane(input int k, input logic [3:0] rob_i, input logic [31:0] d, input logic [5:0] dest);
        case (k)
            1: begin bus.result_valid_c1 = 1'b1; bus.result_ROB_c1 = rob_i; bus.result_c1 = d; bus.result_dest_c1 = dest; end
            2: begin bus.result_valid_c2 = 1'b1; bus.result_ROB_c2 = rob_i; bus.result_c2 = d; bus.result_dest_c2 = dest; end
            default: begin bus.result_valid_c3 = 1'b1; bus.result_ROB_c3 = rob_i; bus.result_c3 = d; bus.result_dest_c3 = dest; end
        endcase
        fq[k-1].push_back({dest, d});
    endtask

    task automatic exp_ret(input logic [4:0] idx, input logic [31:0] res, input logic [5:0] fp);
        rq.push_back({idx, res, fp});
    endtask

    initial begin
        bus.rob_opcode_1 = '0; bus.rob_opcode_2 = '0;
        bus.rob_p_reg_1 = '0; bus.rob_p_reg_2 = '0; bus.o_rob_p_reg_1 = '0; bus.o_rob_p_reg_2 = '0;
        bus.rob_rd_1 = '0; bus.rob_rd_2 = '0; bus.rob_pc_1 = '0; bus.rob_pc_2 = '0;
        bus.result_c1 = '0; bus.result_c2 = '0; bus.result_c3 = '0;
        bus.result_dest_c1 = '0; bus.result_dest_c2 = '0; bus.result_dest_c3 = '0;
        bus.result_ROB_c1 = '0; bus.result_ROB_c2 = '0; bus.result_ROB_c3 = '0;
        bus.result_FU_c1 = 2'd0; bus.result_FU_c2 = 2'd1; bus.result_FU_c3 = 2'd2;
        bus.result_pc_c1 = '0; bus.result_pc_c2 = '0; bus.result_pc_c3 = '0;
        bus.total_instr_count = 32'd0;
        clear_inputs();

        // Reset state
        rst_n = 1'b0;
        cyc();
        cyc();
        compare("rst_fwd_flags", {bus.forward_flag_1, bus.forward_flag_2, bus.forward_flag_3}, 0);
        compare("rst_retire_flags", {bus.retire_flag_1, bus.retire_flag_2, bus.pr_flag}, 0);
        compare("rst_data", {bus.dest_R_1, bus.retire_result_1, bus.fp_ind_1}, 0);
        compare("rst_ready", bus.rob_ready, 1);
        compare("rst_idx1", bus.rob_idx_1, 0);
        compare("rst_idx2", bus.rob_idx_2, 1);
        rst_n = 1'b1;

        // Basic pair: allocate, complete, forward, retire
        alloc(OP_ALU, 6'd32, 6'd5, 5'd5, OP_ALU, 6'd33, 6'd6, 5'd6);
        cyc();
        compare("t2_idx1", bus.rob_idx_1, 2);
        exp_ret(5'd5, 32'h2A, 6'd5);
        exp_ret(5'd6, 32'h7, 6'd6);
        lane(1, 4'd0, 32'h2A, 6'd32);
        lane(2, 4'd1, 32'h7, 6'd33);
        cyc();
        compare("t2_fwd_flags", {bus.forward_flag_1, bus.forward_flag_2}, 2'b11);
        compare("t2_no_early_retire", bus.retire_flag_1, 0);
        cyc();
        compare("t2_retire_both", {bus.retire_flag_1, bus.retire_flag_2}, 2'b11);
        cyc();

        // Out-of-order completion: ROB3 first, ROB2 later
        exp_ret(5'd7, 32'h22, 6'd7);
        exp_ret(5'd8, 32'h33, 6'd8);
        alloc(OP_ALU, 6'd34, 6'd7, 5'd7, OP_ALU, 6'd35, 6'd8, 5'd8);
        cyc();
        lane(1, 4'd3, 32'h33, 6'd35);
        cyc();
        cyc();
        compare("t3_hold_a", bus.retire_flag_1, 0);
        cyc();
        compare("t3_hold_b", bus.retire_flag_1, 0);
        lane(3, 4'd2, 32'h22, 6'd34);
        cyc();
        compare("t3_hold_c", bus.retire_flag_1, 0);
        cyc();
        compare("t3_retire_both", {bus.retire_flag_1, bus.retire_flag_2}, 2'b11);
        cyc();

        // Bubble slot 2 and a lane aimed at an unallocated entry
        alloc(OP_STORE, 6'd36, 6'd9, 5'd9, 7'd0, 6'd0, 6'd0, 5'd0);
        cyc();
        compare("t5_tail_plus1", bus.rob_idx_1, 5);
        lane(2, 4'd5, 32'hBAD, 6'd50);
        cyc();
        cyc();
        compare("t5_invalid_lane", bus.retire_flag_1, 0);
        exp_ret(5'd0, 32'h44, 6'd9);
        lane(1, 4'd4, 32'h44, 6'd36);
        cyc();
        cyc();
        compare("t5_store_single", {bus.retire_flag_1, bus.retire_flag_2}, 2'b10);
        cyc();

        // Fill the ROB from index 5, wrapping through 15 -> 0
        for (int i = 0; i < 7; i++) begin
            alloc(OP_ALU, 6'(40 + 2*i), 6'(20 + 2*i), 5'(2*i + 1), OP_ALU, 6'(41 + 2*i), 6'(21 + 2*i), 5'(2*i + 2));
            cyc();
        end
        compare("t4_ready_at14", bus.rob_ready, 1);
        alloc(OP_ALU, 6'd54, 6'd34, 5'd15, OP_ALU, 6'd55, 6'd35, 5'd16);
        cyc();
        compare("t4_full_ready", bus.rob_ready, 0);
        compare("t4_tail_wrapped", bus.rob_idx_1, 5);
        alloc(OP_ALU, 6'd60, 6'd61, 5'd30, OP_ALU, 6'd62, 6'd63, 5'd31);
        cyc();
        compare("t4_9th_ignored", bus.rob_idx_1, 5);
        compare("t4_still_full", bus.rob_ready, 0);
        for (int i = 0; i < 8; i++) begin
            exp_ret(5'(2*i + 1), 32'h1000 + 32'(2*i), 6'(20 + 2*i));
            exp_ret(5'(2*i + 2), 32'h1001 + 32'(2*i), 6'(21 + 2*i));
            lane(1, 4'((5 + 2*i) % 16), 32'h1000 + 32'(2*i), 6'(40 + 2*i));
            lane(2, 4'((6 + 2*i) % 16), 32'h1001 + 32'(2*i), 6'(41 + 2*i));
            cyc();
        end
        cyc();
        cyc();
        cyc();
        compare("t4_drained_ready", bus.rob_ready, 1);
        alloc(OP_ALU, 6'd1, 6'd2, 5'd3, OP_ALU, 6'd4, 6'd5, 5'd6);
        cyc();
        compare("t4_realloc_idx", bus.rob_idx_1, 7);

        // Reset discards in-flight entries; then end-of-program detection
        rst_n = 1'b0;
        cyc();
        cyc();
        bus.total_instr_count = 32'd4;
        rst_n = 1'b1;
        compare("t6_idx_after_rst", bus.rob_idx_1, 0);
        alloc(OP_ALU, 6'd10, 6'd1, 5'd1, OP_ALU, 6'd11, 6'd2, 5'd2);
        cyc();
        alloc(OP_ALU, 6'd12, 6'd3, 5'd3, OP_LOAD, 6'd13, 6'd4, 5'd4);
        cyc();
        exp_ret(5'd1, 32'hBBBB, 6'd1);
        exp_ret(5'd2, 32'h11, 6'd2);
        exp_ret(5'd3, 32'h22, 6'd3);
        exp_ret(5'd4, 32'h33, 6'd4);
        lane(1, 4'd0, 32'hAAAA, 6'd10);
        lane(2, 4'd0, 32'hBBBB, 6'd10);
        lane(3, 4'd1, 32'h11, 6'd11);
        cyc();
        lane(1, 4'd2, 32'h22, 6'd12);
        lane(2, 4'd3, 32'h33, 6'd13);
        cyc();
        cyc();
        compare("t6_pr_not_yet", bus.pr_flag, 0);
        cyc();
        compare("t6_pr_set", bus.pr_flag, 1);
        cyc();
        cyc();
        compare("t6_pr_sticky", bus.pr_flag, 1);

        compare("fwd1_queue_empty", fq[0].size(), 0);
        compare("fwd2_queue_empty", fq[1].size(), 0);
        compare("fwd3_queue_empty", fq[2].size(), 0);
        compare("retire_queue_empty", rq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
